// File: rtl/pulse_pkg.sv
// Shared types for the pulse compressor: FSM state encoding.
package pulse_pkg;

    typedef enum logic [2:0] {
        WAIT_LOW = 3'd0,
        IDLE     = 3'd1,
        QUAL     = 3'd2,
        ACTIVE   = 3'd3,
        TIMEOUT  = 3'd4
    } state_e;

endpackage

// File: rtl/pulse_sync.sv
// Input synchroniser: STAGES-deep flop chain, cleared by synchronous reset.
module pulse_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign s = chain_q[STAGES-1];

endmodule

// File: rtl/pulse_compressor.sv
// Recovers one single-cycle strobe per stretched input pulse, and qualifies and
// measures the pulse width (glitch rejection, stuck-high timeout).
module pulse_compressor
    import pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MIN_WIDTH   = 4,
    parameter int unsigned MAX_WIDTH   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             pulse_out,
    output logic [CNT_W-1:0] width_out,
    output logic             width_valid,
    output logic             glitch_err,
    output logic             timeout_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_WIDTH);

    logic s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse_out_q, pulse_out_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             width_valid_q, width_valid_d;
    logic             glitch_err_q, glitch_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;

    pulse_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (pulse_in),
        .s  (s)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_LOW;
            cnt_q         <= '0;
            pulse_out_q   <= 1'b0;
            width_q       <= '0;
            width_valid_q <= 1'b0;
            glitch_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pulse_out_q   <= pulse_out_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            glitch_err_q  <= glitch_err_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            // The freshly cleared chain reads low until real samples reach s, so
            // cnt counts those priming edges before the low level is believed.
            WAIT_LOW: begin
                if (cnt_q < SYNC_C) begin
                    cnt_d = cnt_inc;
                end else if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (s) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (MIN_WIDTH == 1) ? ACTIVE : QUAL;
                end
            end
            QUAL: begin
                if (s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MIN_C) begin
                        state_d = ACTIVE;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (s) begin
                    if (cnt_q == MAX_C) begin
                        state_d = TIMEOUT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            TIMEOUT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_out_d   = (state_d == ACTIVE) && (state_q != ACTIVE);
        width_valid_d = (state_q == ACTIVE) && !s;
        glitch_err_d  = (state_q == QUAL) && !s;
        timeout_err_d = (state_q == ACTIVE) && s && (cnt_q == MAX_C);
        width_d       = width_valid_d ? cnt_q : width_q;
        busy_d        = (state_d != IDLE);
    end

    assign pulse_out   = pulse_out_q;
    assign width_out   = width_q;
    assign width_valid = width_valid_q;
    assign glitch_err  = glitch_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_compressor.sv
// Bench for pulse_compressor: run-length reference model, vector table, directed corners, random pulses.
module tb_pulse_compressor;

    localparam int SYNC  = 2;
    localparam int CNT_W = 8;
    localparam int MINW  = 4;
    localparam int MAXW  = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse_in;
    logic             pulse_out;
    logic [CNT_W-1:0] width_out;
    logic             width_valid;
    logic             glitch_err;
    logic             timeout_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: delayed input samples and the current high run length.
    bit hist[$];
    bit m_armed;
    int m_run;
    bit m_pulse, m_wv, m_glitch, m_to, m_busy;
    int m_width;

    int c_pulse, c_wv, c_gl, c_to;

    typedef struct {
        int width;
        int n_pulse;
        int n_wv;
        int n_gl;
        int n_to;
        int width_after;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    pulse_compressor #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (CNT_W),
        .MIN_WIDTH  (MINW),
        .MAX_WIDTH  (MAXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .pulse_out  (pulse_out),
        .width_out  (width_out),
        .width_valid(width_valid),
        .glitch_err (glitch_err),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Pulse semantics by run length: a pulse counts only once a low level has been
    // seen after reset; it is accepted on its MINW-th high sample, times out on the
    // (MAXW+1)-th, and on the fall reports a glitch or its width.
    task automatic model_step(input logic r, input logic p);
        bit sv;
        bit valid;
        m_pulse  = 0;
        m_wv     = 0;
        m_glitch = 0;
        m_to     = 0;
        if (r) begin
            hist.delete();
            m_armed = 0;
            m_run   = 0;
            m_width = 0;
            m_busy  = 0;
            return;
        end
        hist.push_back(p);
        valid = 0;
        sv    = 0;
        if (hist.size() > SYNC) begin
            sv    = hist.pop_front();
            valid = 1;
        end
        if (!m_armed) begin
            if (valid && !sv) m_armed = 1;
            m_busy = !m_armed;
        end else if (sv) begin
            m_run++;
            m_pulse = (m_run == MINW);
            m_to    = (m_run == MAXW + 1);
            m_busy  = 1;
        end else begin
            if (m_run > 0 && m_run < MINW) begin
                m_glitch = 1;
            end else if (m_run >= MINW && m_run <= MAXW) begin
                m_wv    = 1;
                m_width = m_run;
            end
            m_run  = 0;
            m_busy = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, pulse_in);
        #1;
        check("pulse_out", int'(pulse_out), int'(m_pulse));
        check("width_valid", int'(width_valid), int'(m_wv));
        check("width_out", int'(width_out), m_width);
        check("glitch_err", int'(glitch_err), int'(m_glitch));
        check("timeout_err", int'(timeout_err), int'(m_to));
        check("busy", int'(busy), int'(m_busy));
        check("strobe_onehot", int'($countones({pulse_out, width_valid, glitch_err, timeout_err}) <= 1), 1);
        c_pulse += int'(pulse_out);
        c_wv    += int'(width_valid);
        c_gl    += int'(glitch_err);
        c_to    += int'(timeout_err);
    endtask

    task automatic run_level(input logic lvl, input int n);
        pulse_in = lvl;
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        c_pulse = 0;
        c_wv    = 0;
        c_gl    = 0;
        c_to    = 0;
    endtask

    initial begin
        int first_p;
        int first_wv;
        int hl;
        int ll;
        int sel;

        rst      = 1'b1;
        pulse_in = 1'b1;
        clear_counts();

        vecs[0] = '{4,   1, 1, 0, 0, 4};
        vecs[1] = '{3,   0, 0, 1, 0, 4};
        vecs[2] = '{101, 1, 1, 0, 0, 101};
        vecs[3] = '{250, 1, 0, 0, 1, 101};
        vecs[4] = '{200, 1, 1, 0, 0, 200};
        vecs[5] = '{201, 1, 0, 0, 1, 200};
        vecs[6] = '{1,   0, 0, 1, 0, 200};
        vecs[7] = '{5,   1, 1, 0, 0, 5};

        // Input held high across reset must never count as a pulse.
        repeat (2) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_width", int'(width_out), 0);
        check("reset_pulse", int'(pulse_out), 0);
        rst = 1'b0;
        clear_counts();
        run_level(1'b1, 50);
        check("held_high_pulses", c_pulse, 0);
        check("held_high_busy", int'(busy), 1);
        run_level(1'b0, 2);
        check("fall_busy_still", int'(busy), 1);
        tick();
        check("fall_busy_idle", int'(busy), 0);
        run_level(1'b0, 3);

        // Latency of a nominal 101-cycle pulse, first high sample at tick index 0.
        first_p  = -1;
        first_wv = -1;
        pulse_in = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (i == 101) pulse_in = 1'b0;
            tick();
            if (pulse_out && first_p < 0) first_p = i;
            if (width_valid && first_wv < 0) first_wv = i;
        end
        check("latency_pulse_out", first_p, SYNC + MINW - 1);
        check("latency_width_valid", first_wv, 101 + SYNC);
        check("latency_width", int'(width_out), 101);

        for (int v = 0; v < 8; v++) begin
            clear_counts();
            run_level(1'b1, vecs[v].width);
            run_level(1'b0, 12);
            check("vec_pulse_cnt", c_pulse, vecs[v].n_pulse);
            check("vec_wv_cnt", c_wv, vecs[v].n_wv);
            check("vec_glitch_cnt", c_gl, vecs[v].n_gl);
            check("vec_timeout_cnt", c_to, vecs[v].n_to);
            check("vec_width_out", int'(width_out), vecs[v].width_after);
        end

        // Back-to-back pulses with a single low cycle, then reset mid third pulse.
        clear_counts();
        run_level(1'b1, 101);
        run_level(1'b0, 1);
        run_level(1'b1, 101);
        run_level(1'b0, 10);
        check("b2b_pulses", c_pulse, 2);
        check("b2b_wv", c_wv, 2);
        check("b2b_width", int'(width_out), 101);
        run_level(1'b1, 30);
        rst = 1'b1;
        tick();
        check("midrst_busy", int'(busy), 0);
        check("midrst_width", int'(width_out), 0);
        check("midrst_pulse", int'(pulse_out), 0);
        rst = 1'b0;
        tick();
        check("midrst_wait_low", int'(busy), 1);
        run_level(1'b1, 20);
        run_level(1'b0, 5);

        for (int seg = 0; seg < 80; seg++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       hl = int'($urandom_range(1, 6));
                1:       hl = int'($urandom_range(95, 105));
                2:       hl = int'($urandom_range(197, 203));
                3:       hl = int'($urandom_range(7, 40));
                default: hl = int'($urandom_range(230, 260));
            endcase
            ll = int'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) begin
                pulse_in = 1'($urandom_range(0, 1));
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            run_level(1'b1, hl);
            run_level(1'b0, ll);
        end
        run_level(1'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
